mips_regfile_sb: RTL and testbench



---
 rtl/mips_rf_pkg.sv | 10 +
 rtl/mips_rf_scoreboard.sv | 52 +++++
 rtl/mips_regfile_sb.sv | 92 +++++++++
 tb/tb_mips_regfile_sb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// Shared defaults and types for the MIPS register file with load scoreboard.
package mips_rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_NREGS);
  localparam int ZERO_IDX   = 0;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register outstanding-load tracker: pending bits, sticky double-issue
// error and a registered count of pending registers.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [NREGS-1:0]  pend_vec,
  output logic [NREGS-1:0]  set_vec,
  output logic [NREGS-1:0]  clr_vec,
  output logic              sb_err,
  output logic [ADDR_W:0]   pend_cnt
);
  logic [NREGS-1:0] pend_next;
  logic             err_hit;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + (ADDR_W+1)'(v[i]);
    return n;
  endfunction

  // A same-cycle issue overrides a retire, so a back-to-back reissue stays pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && iss_addr != ADDR_W'(ZERO_IDX)) set_vec[iss_addr] = 1'b1;
    if (ret_valid && ret_addr != ADDR_W'(ZERO_IDX)) clr_vec[ret_addr] = 1'b1;
    pend_next = (pend_vec & ~clr_vec) | set_vec;
    err_hit   = |(set_vec & pend_vec & ~clr_vec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vec <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend_vec <= pend_next;
      pend_cnt <= popcount(pend_next);
      if (err_hit) sb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS integer register file: NRD async read ports, ALU and load write ports,
// load scoreboard. Optional same-cycle forwarding under REGFILE_BYPASS_EN.
module mips_regfile_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pending,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  sb_err,
  output logic [ADDR_W:0]       pend_cnt
);
  if ((NREGS & (NREGS - 1)) != 0 || NREGS < 8 || NREGS > 64 ||
      NRD < 2 || NRD > 4 || ADDR_W != $clog2(NREGS)) begin : g_bad_params
    $error("mips_regfile_sb: illegal NREGS/NRD/ADDR_W combination");
  end

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend_vec, set_vec, clr_vec;
  logic              wr0_en, wr1_en;

  mips_rf_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .ret_valid (we1),
    .ret_addr  (wa1),
    .pend_vec  (pend_vec),
    .set_vec   (set_vec),
    .clr_vec   (clr_vec),
    .sb_err    (sb_err),
    .pend_cnt  (pend_cnt)
  );

  // Load writeback wins a same-index collision; the ALU write is dropped.
  assign wr1_en = we1 && wa1 != ADDR_W'(ZERO_IDX);
  assign wr0_en = we0 && wa0 != ADDR_W'(ZERO_IDX) && !(wr1_en && wa1 == wa0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr0_en) regs[wa0] <= wd0;
      if (wr1_en) regs[wa1] <= wd1;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{set_vec, clr_vec};
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign idx = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs[idx];
      pend = pend_vec[idx];
`ifdef REGFILE_BYPASS_EN
      if (wr1_en && wa1 == idx)      data = wd1;
      else if (wr0_en && wa0 == idx) data = wd0;
      if (clr_vec[idx] && !set_vec[idx]) pend = 1'b0;
`endif
      if (idx == ADDR_W'(ZERO_IDX)) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_pending[k]               = pend;
  end
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed and randomized bench for mips_regfile_sb (NRD=4, NREGS=16).
module tb_mips_regfile_sb;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int NRD    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_pending;
  logic                  we0, we1, iss_valid;
  logic [ADDR_W-1:0]     wa0, wa1, iss_addr;
  logic [DATA_W-1:0]     wd0, wd1;
  logic                  sb_err;
  logic [ADDR_W:0]       pend_cnt;

  mips_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
    .wa1(wa1), .wd1(wd1), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .sb_err(sb_err), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: architectural register values, pending flags, sticky error.
  logic [DATA_W-1:0] m_regs [NREGS];
  bit                m_pend [NREGS];
  bit                m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_pend(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a && !(iss_valid && int'(iss_addr) == a)) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_update();
    int a0 = int'(wa0);
    int a1 = int'(wa1);
    int ai = int'(iss_addr);
    if (we0 && a0 != 0) m_regs[a0] = wd0;
    if (we1 && a1 != 0) m_regs[a1] = wd1;
    if (iss_valid && ai != 0 && m_pend[ai] && !(we1 && a1 == ai)) m_err = 1'b1;
    if (we1 && a1 != 0) m_pend[a1] = 1'b0;
    if (iss_valid && ai != 0) m_pend[ai] = 1'b1;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NRD; k++) begin
      int a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
      chk($sformatf("rd_data%0d(r%0d)", k, a), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_data(a)));
      chk($sformatf("rd_pending%0d(r%0d)", k, a), 64'(rd_pending[k]), 64'(exp_pend(a)));
    end
    chk("sb_err", 64'(sb_err), 64'(m_err));
    chk("pend_cnt", 64'(pend_cnt), 64'(model_cnt()));
  endtask

  // Check during the low phase, then let the edge commit into DUT and model.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    iss_valid = 0; iss_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic async_reset_pulse();
    #1 reset = 1'b1;
    #1;
    chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Mid-run asynchronous reset clears data, pending and count at once.
    set_rd(0, 5); set_rd(1, 7);
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_valid = 1; iss_addr = 7;
    step(); idle(); #1;
    chk("r5_written", 64'(rd_data[DATA_W-1:0]), 64'hDEADBEEF);
    chk("r7_pending", 64'(rd_pending[1]), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_r5", 64'(rd_data[DATA_W-1:0]), 64'd0);
    chk("rst_r7_pend", 64'(rd_pending[1]), 64'd0);
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_err", 64'(sb_err), 64'd0);
    model_reset();
    reset = 1'b0;

    // Same-index dual write: load port wins. Writes to r0 are ignored.
    set_rd(0, 9); set_rd(1, 0);
    we0 = 1; wa0 = 9; wd0 = 32'h11; we1 = 1; wa1 = 9; wd1 = 32'h22;
    step(); idle();
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
    step(); idle(); #1;
    chk("r9_port1_wins", 64'(rd_data[DATA_W-1:0]), 64'h22);
    chk("r0_zero", 64'(rd_data[2*DATA_W-1:DATA_W]), 64'd0);

    // Load to r12: pending across the shadow, retired by the load write.
    set_rd(0, 12);
    iss_valid = 1; iss_addr = 12;
    step(); idle(); #1;
    chk("r12_pend_c1", 64'(rd_pending[0]), 64'd1);
    chk("r12_cnt_c1", 64'(pend_cnt), 64'd1);
    step(); step();
    chk("r12_pend_c3", 64'(rd_pending[0]), 64'd1);
    we1 = 1; wa1 = 12; wd1 = 32'hABCD;
    step(); idle(); #1;
    chk("r12_pend_c4", 64'(rd_pending[0]), 64'd0);
    chk("r12_cnt_c4", 64'(pend_cnt), 64'd0);
    chk("r12_data", 64'(rd_data[DATA_W-1:0]), 64'hABCD);

    // Back-to-back reissue keeps r3 pending; a plain reissue sets sb_err.
    set_rd(0, 3);
    iss_valid = 1; iss_addr = 3;
    step(); idle();
    iss_valid = 1; iss_addr = 3; we1 = 1; wa1 = 3; wd1 = 32'h77;
    step(); idle(); #1;
    chk("r3_still_pend", 64'(rd_pending[0]), 64'd1);
    chk("r3_cnt", 64'(pend_cnt), 64'd1);
    chk("r3_no_err", 64'(sb_err), 64'd0);
    iss_valid = 1; iss_addr = 3;
    step(); idle(); #1;
    chk("r3_err_set", 64'(sb_err), 64'd1);
    step(); step();
    chk("r3_err_sticky", 64'(sb_err), 64'd1);
    async_reset_pulse();

    // Same-cycle read of a register being written by the ALU port.
    we0 = 1; wa0 = 4; wd0 = 32'h10;
    step(); idle();
    set_rd(0, 4);
    we0 = 1; wa0 = 4; wd0 = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r4_same_cycle", 64'(rd_data[DATA_W-1:0]), 64'h55);
`else
    chk("r4_same_cycle", 64'(rd_data[DATA_W-1:0]), 64'h10);
`endif
    step(); idle(); #1;
    chk("r4_next_cycle", 64'(rd_data[DATA_W-1:0]), 64'h55);

    // Randomized regression against the model, with occasional async resets.
    for (int i = 0; i < 10000; i++) begin
      rd_addr   = (NRD*ADDR_W)'($urandom);
      we0       = 1'($urandom_range(0, 1));
      wa0       = ADDR_W'($urandom);
      wd0       = $urandom;
      we1       = ($urandom_range(0, 2) == 0);
      wa1       = ADDR_W'($urandom);
      wd1       = $urandom;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_addr  = ADDR_W'($urandom);
      step();
      if (i % 1500 == 1499) begin
        idle();
        async_reset_pulse();
      end
    end
    idle();
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
